// File: rtl/ls_exec_unit.sv
// ls_exec_unit: load/store execution stage between the LS buffer, the memory
// controller and the ROB/CDB. Computes rs1+imm, runs the MC request/done
// handshake, extends load data, and holds stores until their ROB commit.
// Optional build macro LS_IO_ORDER_EN: loads in the IO region wait for ROB
// commit before touching memory.
module ls_exec_unit #(
  parameter int unsigned ROB_ID_W   = 4,
  parameter int unsigned DATA_W     = 32,
  parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                LSB_input_valid,
  input  logic [3:0]          LSB_ls_op,
  input  logic [DATA_W-1:0]   LSB_reg_rs1,
  input  logic [DATA_W-1:0]   LSB_reg_rs2,
  input  logic [DATA_W-1:0]   LSB_imm,
  input  logic [ROB_ID_W-1:0] LSB_ROB_id,
  output logic                LSB_busy,
  output logic                MC_req_valid,
  output logic                MC_is_write,
  output logic [DATA_W-1:0]   MC_addr,
  output logic [1:0]          MC_size,
  output logic [DATA_W-1:0]   MC_wdata,
  input  logic                MC_done,
  input  logic [DATA_W-1:0]   MC_rdata,
  input  logic                ROB_commit_valid,
  input  logic [ROB_ID_W-1:0] ROB_commit_id,
  input  logic                ROB_clear,
  output logic                CDB_valid,
  output logic [ROB_ID_W-1:0] CDB_ROB_id,
  output logic [DATA_W-1:0]   CDB_value,
  output logic [DATA_W-1:0]   CDB_addr
);

`ifdef LS_IO_ORDER_EN
  localparam bit IoOrderEn = 1'b1;
`else
  localparam bit IoOrderEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MEM_WAIT   = 2'd1,
    STORE_WAIT = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]          op_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   rs2_q;
  logic [ROB_ID_W-1:0] tag_q;
  logic                committed_q;

  logic                cdb_valid_q;
  logic                cdb_pend_q;
  logic [ROB_ID_W-1:0] cdb_id_q;
  logic [DATA_W-1:0]   cdb_value_q;
  logic [DATA_W-1:0]   cdb_addr_q;

  logic [DATA_W-1:0]   issue_addr;
  logic                issue_io;
  logic                accept;
  logic                commit_hit;
  logic                store_fire;
  logic                load_fire;
  logic                pend_fire;

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                     input logic [2:0] op);
    logic [DATA_W-1:0] v;
    v = raw;
    case (op[1:0])
      2'b00:   v = {{(DATA_W-8){op[2] ? 1'b0 : raw[7]}}, raw[7:0]};
      2'b01:   v = {{(DATA_W-16){op[2] ? 1'b0 : raw[15]}}, raw[15:0]};
      default: v = raw;
    endcase
    return v;
  endfunction

  assign issue_addr = LSB_reg_rs1 + LSB_imm;
  assign issue_io   = IoOrderEn && !LSB_ls_op[3] && (issue_addr[17:16] == IO_BASE_HI);
  assign accept     = LSB_input_valid && (state_q == IDLE) && !ROB_clear;
  assign commit_hit = ROB_commit_valid && (ROB_commit_id == tag_q);

  assign LSB_busy     = (state_q != IDLE);
  assign MC_req_valid = (state_q == MEM_WAIT) || (state_q == DRAIN);
  assign MC_is_write  = MC_req_valid && op_q[3];
  assign MC_addr      = addr_q;
  assign MC_size      = op_q[1:0];
  assign MC_wdata     = rs2_q;
  assign CDB_valid    = cdb_valid_q;
  assign CDB_ROB_id   = cdb_id_q;
  assign CDB_value    = cdb_value_q;
  assign CDB_addr     = cdb_addr_q;

  // State register; rdy=0 freezes the machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else if (rdy) state_q <= state_d;
  end

  // Next-state and CDB-fire decisions.
  always_comb begin
    state_d    = state_q;
    store_fire = 1'b0;
    load_fire  = 1'b0;
    pend_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LSB_ls_op[3]) begin
            state_d    = STORE_WAIT;
            store_fire = 1'b1;
          end else if (issue_io) begin
            state_d = STORE_WAIT;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      STORE_WAIT: begin
        pend_fire = cdb_pend_q && !ROB_clear;
        if (commit_hit)     state_d = MEM_WAIT;
        else if (ROB_clear) state_d = IDLE;
      end
      MEM_WAIT: begin
        if (MC_done) begin
          state_d   = IDLE;
          load_fire = !op_q[3] && !ROB_clear;
        end else if (ROB_clear && !op_q[3] && !committed_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (MC_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and CDB output registers.
  // A store accepted in the same cycle as a load's CDB pulse defers its own
  // pulse by one cycle (cdb_pend_q) so CDB_valid never stays high twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      addr_q      <= '0;
      rs2_q       <= '0;
      tag_q       <= '0;
      committed_q <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_pend_q  <= 1'b0;
      cdb_id_q    <= '0;
      cdb_value_q <= '0;
      cdb_addr_q  <= '0;
    end else if (rdy) begin
      if (accept) begin
        op_q        <= LSB_ls_op;
        addr_q      <= issue_addr;
        rs2_q       <= LSB_reg_rs2;
        tag_q       <= LSB_ROB_id;
        committed_q <= 1'b0;
      end else if (state_q == STORE_WAIT && commit_hit) begin
        committed_q <= 1'b1;
      end
      cdb_pend_q  <= store_fire && cdb_valid_q;
      cdb_valid_q <= (store_fire && !cdb_valid_q) || load_fire || pend_fire;
      if (store_fire && !cdb_valid_q) begin
        cdb_id_q    <= LSB_ROB_id;
        cdb_value_q <= LSB_reg_rs2;
        cdb_addr_q  <= issue_addr;
      end else if (pend_fire) begin
        cdb_id_q    <= tag_q;
        cdb_value_q <= rs2_q;
        cdb_addr_q  <= addr_q;
      end else if (load_fire) begin
        cdb_id_q    <= tag_q;
        cdb_value_q <= load_extend(MC_rdata, op_q[2:0]);
        cdb_addr_q  <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_ls_exec_unit.sv
// tb_ls_exec_unit: directed scenarios for ls_exec_unit with hand-computed
// expected values.
module tb_ls_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        LSB_input_valid;
  logic [3:0]  LSB_ls_op;
  logic [31:0] LSB_reg_rs1;
  logic [31:0] LSB_reg_rs2;
  logic [31:0] LSB_imm;
  logic [3:0]  LSB_ROB_id;
  logic        LSB_busy;
  logic        MC_req_valid;
  logic        MC_is_write;
  logic [31:0] MC_addr;
  logic [1:0]  MC_size;
  logic [31:0] MC_wdata;
  logic        MC_done;
  logic [31:0] MC_rdata;
  logic        ROB_commit_valid;
  logic [3:0]  ROB_commit_id;
  logic        ROB_clear;
  logic        CDB_valid;
  logic [3:0]  CDB_ROB_id;
  logic [31:0] CDB_value;
  logic [31:0] CDB_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ls_exec_unit #(.ROB_ID_W(4), .DATA_W(32), .IO_BASE_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .LSB_input_valid(LSB_input_valid), .LSB_ls_op(LSB_ls_op),
    .LSB_reg_rs1(LSB_reg_rs1), .LSB_reg_rs2(LSB_reg_rs2), .LSB_imm(LSB_imm),
    .LSB_ROB_id(LSB_ROB_id), .LSB_busy(LSB_busy),
    .MC_req_valid(MC_req_valid), .MC_is_write(MC_is_write), .MC_addr(MC_addr),
    .MC_size(MC_size), .MC_wdata(MC_wdata), .MC_done(MC_done), .MC_rdata(MC_rdata),
    .ROB_commit_valid(ROB_commit_valid), .ROB_commit_id(ROB_commit_id),
    .ROB_clear(ROB_clear),
    .CDB_valid(CDB_valid), .CDB_ROB_id(CDB_ROB_id), .CDB_value(CDB_value),
    .CDB_addr(CDB_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] i,
                             input logic [3:0] id);
    LSB_input_valid = 1'b1;
    LSB_ls_op = op; LSB_reg_rs1 = a; LSB_reg_rs2 = d; LSB_imm = i; LSB_ROB_id = id;
    tick();
    LSB_input_valid = 1'b0;
  endtask

  task automatic mc_done_pulse(input logic [31:0] data);
    MC_done = 1'b1; MC_rdata = data;
    tick();
    MC_done = 1'b0; MC_rdata = '0;
  endtask

  task automatic commit_pulse(input logic [3:0] id);
    ROB_commit_valid = 1'b1; ROB_commit_id = id;
    tick();
    ROB_commit_valid = 1'b0; ROB_commit_id = '0;
  endtask

  task automatic clear_pulse();
    ROB_clear = 1'b1;
    tick();
    ROB_clear = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (LSB_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", LSB_busy); end
    checks++; if (MC_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", MC_req_valid); end
    checks++; if (CDB_valid !== 1'b0) begin errors++; $display("FAIL rst_cdb: got %b expected 0", CDB_valid); end
    checks++; if (MC_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", MC_addr); end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (LSB_busy !== 1'b0 || MC_req_valid !== 1'b0) begin errors++; $display("FAIL rst_idle: busy=%b req=%b expected 0 0", LSB_busy, MC_req_valid); end
  endtask

  task automatic test_signed_byte();
    drive_issue(4'b0000, 32'h100, 32'h0, 32'hFFFFFFFC, 4'd3);
    checks++; if (MC_req_valid !== 1'b1) begin errors++; $display("FAIL sb_req: got %b expected 1", MC_req_valid); end
    checks++; if (MC_is_write !== 1'b0) begin errors++; $display("FAIL sb_wr: got %b expected 0", MC_is_write); end
    checks++; if (MC_addr !== 32'hFC) begin errors++; $display("FAIL sb_addr: got %h expected 000000fc", MC_addr); end
    checks++; if (MC_size !== 2'b00) begin errors++; $display("FAIL sb_size: got %b expected 00", MC_size); end
    checks++; if (LSB_busy !== 1'b1) begin errors++; $display("FAIL sb_busy: got %b expected 1", LSB_busy); end
    tick(); tick();
    checks++; if (MC_req_valid !== 1'b1) begin errors++; $display("FAIL sb_req_hold: got %b expected 1", MC_req_valid); end
    mc_done_pulse(32'h000000F0);
    checks++; if (CDB_valid !== 1'b1) begin errors++; $display("FAIL sb_cdb: got %b expected 1", CDB_valid); end
    checks++; if (CDB_value !== 32'hFFFFFFF0) begin errors++; $display("FAIL sb_value: got %h expected fffffff0", CDB_value); end
    checks++; if (CDB_ROB_id !== 4'd3) begin errors++; $display("FAIL sb_id: got %0d expected 3", CDB_ROB_id); end
    checks++; if (CDB_addr !== 32'hFC) begin errors++; $display("FAIL sb_cdb_addr: got %h expected 000000fc", CDB_addr); end
    checks++; if (MC_req_valid !== 1'b0) begin errors++; $display("FAIL sb_req_drop: got %b expected 0", MC_req_valid); end
    tick();
    checks++; if (CDB_valid !== 1'b0) begin errors++; $display("FAIL sb_single: got %b expected 0", CDB_valid); end
  endtask

  task automatic test_unsigned_half();
    drive_issue(4'b0101, 32'h200, 32'h0, 32'h4, 4'd7);
    for (int k = 0; k < 2; k++) begin
      checks++; if (LSB_busy !== 1'b1) begin errors++; $display("FAIL uh_busy%0d: got %b expected 1", k, LSB_busy); end
      tick();
    end
    mc_done_pulse(32'h1234ABCD);
    checks++; if (CDB_valid !== 1'b1 || CDB_value !== 32'h0000ABCD) begin errors++; $display("FAIL uh_value: valid=%b value=%h expected 1 0000abcd", CDB_valid, CDB_value); end
    checks++; if (CDB_ROB_id !== 4'd7 || CDB_addr !== 32'h204) begin errors++; $display("FAIL uh_tag: id=%0d addr=%h expected 7 00000204", CDB_ROB_id, CDB_addr); end
    checks++; if (LSB_busy !== 1'b0) begin errors++; $display("FAIL uh_busy_end: got %b expected 0", LSB_busy); end
    tick();
  endtask

  task automatic test_extend_mix();
    logic [3:0]  ops  [4] = '{4'b0001, 4'b0100, 4'b0110, 4'b0010};
    logic [31:0] raws [4] = '{32'h00008001, 32'hFFFFFF80, 32'h80000001, 32'hCAFEF00D};
    logic [31:0] exps [4] = '{32'hFFFF8001, 32'h00000080, 32'h80000001, 32'hCAFEF00D};
    for (int k = 0; k < 4; k++) begin
      drive_issue(ops[k], 32'h40, 32'h0, 32'(k * 4), 4'(k + 8));
      mc_done_pulse(raws[k]);
      checks++; if (CDB_valid !== 1'b1 || CDB_value !== exps[k]) begin errors++; $display("FAIL ext%0d: valid=%b value=%h expected 1 %h", k, CDB_valid, CDB_value, exps[k]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    drive_issue(4'b0000, 32'h10, 32'h0, 32'h0, 4'd1);
    mc_done_pulse(32'h0000007F);
    checks++; if (CDB_valid !== 1'b1 || CDB_value !== 32'h7F) begin errors++; $display("FAIL b2b_load: valid=%b value=%h expected 1 0000007f", CDB_valid, CDB_value); end
    drive_issue(4'b1010, 32'h20, 32'h11223344, 32'h0, 4'hA);
    checks++; if (CDB_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 0", CDB_valid); end
    checks++; if (LSB_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", LSB_busy); end
    tick();
    checks++; if (CDB_valid !== 1'b1 || CDB_value !== 32'h11223344 || CDB_ROB_id !== 4'hA || CDB_addr !== 32'h20) begin
      errors++; $display("FAIL b2b_store: valid=%b value=%h id=%0d addr=%h expected 1 11223344 10 00000020", CDB_valid, CDB_value, CDB_ROB_id, CDB_addr);
    end
    tick();
    checks++; if (CDB_valid !== 1'b0) begin errors++; $display("FAIL b2b_single: got %b expected 0", CDB_valid); end
    clear_pulse();
    checks++; if (LSB_busy !== 1'b0 || MC_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear: busy=%b req=%b expected 0 0", LSB_busy, MC_req_valid); end
  endtask

  task automatic test_store();
    drive_issue(4'b1010, 32'h1000, 32'hDEADBEEF, 32'h8, 4'd5);
    checks++; if (CDB_valid !== 1'b1 || CDB_value !== 32'hDEADBEEF || CDB_ROB_id !== 4'd5 || CDB_addr !== 32'h1008) begin
      errors++; $display("FAIL st_cdb: valid=%b value=%h id=%0d addr=%h expected 1 deadbeef 5 00001008", CDB_valid, CDB_value, CDB_ROB_id, CDB_addr);
    end
    checks++; if (MC_req_valid !== 1'b0 || LSB_busy !== 1'b1) begin errors++; $display("FAIL st_wait: req=%b busy=%b expected 0 1", MC_req_valid, LSB_busy); end
    tick();
    checks++; if (CDB_valid !== 1'b0) begin errors++; $display("FAIL st_single: got %b expected 0", CDB_valid); end
    commit_pulse(4'd4);
    checks++; if (MC_req_valid !== 1'b0 || LSB_busy !== 1'b1) begin errors++; $display("FAIL st_wrong_id: req=%b busy=%b expected 0 1", MC_req_valid, LSB_busy); end
    mc_done_pulse(32'h0);
    checks++; if (MC_req_valid !== 1'b0 || LSB_busy !== 1'b1) begin errors++; $display("FAIL st_stray_done: req=%b busy=%b expected 0 1", MC_req_valid, LSB_busy); end
    commit_pulse(4'd5);
    checks++; if (MC_req_valid !== 1'b1 || MC_is_write !== 1'b1) begin errors++; $display("FAIL st_req: req=%b wr=%b expected 1 1", MC_req_valid, MC_is_write); end
    checks++; if (MC_wdata !== 32'hDEADBEEF || MC_addr !== 32'h1008 || MC_size !== 2'b10) begin
      errors++; $display("FAIL st_payload: wdata=%h addr=%h size=%b expected deadbeef 00001008 10", MC_wdata, MC_addr, MC_size);
    end
    tick();
    mc_done_pulse(32'h0);
    checks++; if (MC_req_valid !== 1'b0 || LSB_busy !== 1'b0 || CDB_valid !== 1'b0) begin
      errors++; $display("FAIL st_done: req=%b busy=%b cdb=%b expected 0 0 0", MC_req_valid, LSB_busy, CDB_valid);
    end
    tick();
    checks++; if (CDB_valid !== 1'b0) begin errors++; $display("FAIL st_no_second: got %b expected 0", CDB_valid); end
  endtask

  task automatic test_clear_store();
    drive_issue(4'b1000, 32'h300, 32'hAB, 32'h0, 4'd2);
    clear_pulse();
    checks++; if (LSB_busy !== 1'b0) begin errors++; $display("FAIL cs_idle: got %b expected 0", LSB_busy); end
    commit_pulse(4'd2);
    for (int k = 0; k < 3; k++) begin
      checks++; if (MC_req_valid !== 1'b0) begin errors++; $display("FAIL cs_noreq%0d: got %b expected 0", k, MC_req_valid); end
      tick();
    end
  endtask

  task automatic test_clear_load();
    drive_issue(4'b0000, 32'h400, 32'h0, 32'h0, 4'd6);
    clear_pulse();
    checks++; if (MC_req_valid !== 1'b1 || LSB_busy !== 1'b1) begin errors++; $display("FAIL cl_drain: req=%b busy=%b expected 1 1", MC_req_valid, LSB_busy); end
    tick();
    checks++; if (MC_req_valid !== 1'b1) begin errors++; $display("FAIL cl_hold: got %b expected 1", MC_req_valid); end
    mc_done_pulse(32'h12);
    checks++; if (MC_req_valid !== 1'b0 || CDB_valid !== 1'b0 || LSB_busy !== 1'b0) begin
      errors++; $display("FAIL cl_end: req=%b cdb=%b busy=%b expected 0 0 0", MC_req_valid, CDB_valid, LSB_busy);
    end
    tick();
    checks++; if (CDB_valid !== 1'b0) begin errors++; $display("FAIL cl_nocdb: got %b expected 0", CDB_valid); end
    drive_issue(4'b0000, 32'h500, 32'h0, 32'h1, 4'd1);
    checks++; if (MC_req_valid !== 1'b1 || MC_addr !== 32'h501) begin errors++; $display("FAIL cl_reissue: req=%b addr=%h expected 1 00000501", MC_req_valid, MC_addr); end
    mc_done_pulse(32'h7F);
    checks++; if (CDB_valid !== 1'b1 || CDB_value !== 32'h7F || CDB_ROB_id !== 4'd1) begin
      errors++; $display("FAIL cl_new_cdb: valid=%b value=%h id=%0d expected 1 0000007f 1", CDB_valid, CDB_value, CDB_ROB_id);
    end
    tick();
  endtask

  task automatic test_clear_drop();
    ROB_clear = 1'b1;
    drive_issue(4'b0000, 32'h600, 32'h0, 32'h0, 4'd4);
    ROB_clear = 1'b0;
    checks++; if (LSB_busy !== 1'b0 || MC_req_valid !== 1'b0) begin errors++; $display("FAIL cd_drop: busy=%b req=%b expected 0 0", LSB_busy, MC_req_valid); end
  endtask

  task automatic test_commit_clear_race();
    drive_issue(4'b1001, 32'h500, 32'hBEEF, 32'h2, 4'd9);
    tick();
    ROB_clear = 1'b1;
    commit_pulse(4'd9);
    ROB_clear = 1'b0;
    checks++; if (MC_req_valid !== 1'b1 || MC_is_write !== 1'b1) begin errors++; $display("FAIL race_commit: req=%b wr=%b expected 1 1", MC_req_valid, MC_is_write); end
    clear_pulse();
    checks++; if (MC_req_valid !== 1'b1) begin errors++; $display("FAIL race_keep: got %b expected 1", MC_req_valid); end
    mc_done_pulse(32'h0);
    checks++; if (LSB_busy !== 1'b0 || CDB_valid !== 1'b0) begin errors++; $display("FAIL race_done: busy=%b cdb=%b expected 0 0", LSB_busy, CDB_valid); end
  endtask

  task automatic test_async_reset();
    drive_issue(4'b0000, 32'h600, 32'h0, 32'h0, 4'd3);
    #2 rst = 1'b1;
    #1;
    checks++; if (LSB_busy !== 1'b0 || MC_req_valid !== 1'b0 || MC_is_write !== 1'b0) begin
      errors++; $display("FAIL ar_ctrl: busy=%b req=%b wr=%b expected 0 0 0", LSB_busy, MC_req_valid, MC_is_write);
    end
    checks++; if (MC_addr !== 32'h0 || MC_size !== 2'b00 || MC_wdata !== 32'h0) begin
      errors++; $display("FAIL ar_mc: addr=%h size=%b wdata=%h expected 0 0 0", MC_addr, MC_size, MC_wdata);
    end
    checks++; if (CDB_valid !== 1'b0 || CDB_ROB_id !== 4'd0 || CDB_value !== 32'h0 || CDB_addr !== 32'h0) begin
      errors++; $display("FAIL ar_cdb: valid=%b id=%0d value=%h addr=%h expected 0 0 0 0", CDB_valid, CDB_ROB_id, CDB_value, CDB_addr);
    end
    #2 rst = 1'b0;
    tick();
    checks++; if (LSB_busy !== 1'b0) begin errors++; $display("FAIL ar_after: got %b expected 0", LSB_busy); end
  endtask

  task automatic test_rdy_stall();
    int cdb_edge;
    logic [31:0] cdb_val;
    cdb_edge = -1;
    cdb_val = '0;
    drive_issue(4'b0000, 32'h700, 32'h0, 32'h0, 4'hC);
    for (int k = 1; k <= 10; k++) begin
      rdy     = !(k >= 2 && k <= 5);
      MC_done = (k == 3 || k == 7);
      MC_rdata = (k == 7) ? 32'h000000AA : 32'h00000055;
      tick();
      if (CDB_valid === 1'b1 && cdb_edge < 0) begin
        cdb_edge = k;
        cdb_val  = CDB_value;
      end
      if (k == 4) begin
        checks++; if (MC_req_valid !== 1'b1) begin errors++; $display("FAIL rdy_frozen: req=%b expected 1", MC_req_valid); end
      end
    end
    rdy = 1'b1; MC_done = 1'b0; MC_rdata = '0;
    checks++; if (cdb_edge != 7) begin errors++; $display("FAIL rdy_latency: cdb edge %0d expected 7", cdb_edge); end
    checks++; if (cdb_val !== 32'hFFFFFFAA) begin errors++; $display("FAIL rdy_value: got %h expected ffffffaa", cdb_val); end
    checks++; if (LSB_busy !== 1'b0) begin errors++; $display("FAIL rdy_idle: got %b expected 0", LSB_busy); end
  endtask

  task automatic test_io_load();
    drive_issue(4'b0010, 32'h30000, 32'h0, 32'h0, 4'd8);
`ifdef LS_IO_ORDER_EN
    checks++; if (MC_req_valid !== 1'b0 || CDB_valid !== 1'b0) begin errors++; $display("FAIL io_gate: req=%b cdb=%b expected 0 0", MC_req_valid, CDB_valid); end
    tick();
    checks++; if (MC_req_valid !== 1'b0) begin errors++; $display("FAIL io_wait: got %b expected 0", MC_req_valid); end
    commit_pulse(4'd8);
    checks++; if (MC_req_valid !== 1'b1 || MC_is_write !== 1'b0 || MC_addr !== 32'h30000) begin
      errors++; $display("FAIL io_req: req=%b wr=%b addr=%h expected 1 0 00030000", MC_req_valid, MC_is_write, MC_addr);
    end
`else
    checks++; if (MC_req_valid !== 1'b1 || MC_addr !== 32'h30000) begin errors++; $display("FAIL io_plain: req=%b addr=%h expected 1 00030000", MC_req_valid, MC_addr); end
`endif
    mc_done_pulse(32'h55);
    checks++; if (CDB_valid !== 1'b1 || CDB_value !== 32'h55 || CDB_ROB_id !== 4'd8) begin
      errors++; $display("FAIL io_cdb: valid=%b value=%h id=%0d expected 1 00000055 8", CDB_valid, CDB_value, CDB_ROB_id);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    LSB_input_valid = 1'b0; LSB_ls_op = '0; LSB_reg_rs1 = '0; LSB_reg_rs2 = '0;
    LSB_imm = '0; LSB_ROB_id = '0; MC_done = 1'b0; MC_rdata = '0;
    ROB_commit_valid = 1'b0; ROB_commit_id = '0; ROB_clear = 1'b0;
    test_reset();
    test_signed_byte();
    test_unsigned_half();
    test_extend_mix();
    test_back_to_back();
    test_store();
    test_clear_store();
    test_clear_load();
    test_clear_drop();
    test_commit_clear_race();
    test_async_reset();
    test_rdy_stall();
    test_io_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ls_exec_unit.md
Name: ls_exec_unit

Overview:
- Downstream consumer of the load/store buffer. Accepts one issued load/store per handshake and computes the effective address rs1+imm.
- Performs the access through the memory controller's request/done handshake, then broadcasts load results (or store readiness) to the ROB/CDB.
- Stores are held until the ROB commits them. A ROB clear squashes uncommitted work without breaking an in-flight memory transaction.

Parameters:
- ROB_ID_W, 4, width of ROB ids
- DATA_W, 32, data/address width
- IO_BASE_HI, 2'b11, value of addr[17:16] that marks the IO region (used only by the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; 0 freezes all state, outputs hold
- LSB_input_valid  in  1  issue strobe from LS buffer
- LSB_ls_op  in  4  [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word)
- LSB_reg_rs1  in  32  base
- LSB_reg_rs2  in  32  store data
- LSB_imm  in  32  sign-extended offset
- LSB_ROB_id  in  ROB_ID_W  tag
- LSB_busy  out  1  1 = do not issue this cycle
- MC_req_valid  out  1  memory request, level, held until MC_done
- MC_is_write  out  1
- MC_addr  out  32
- MC_size  out  2  same encoding as ls_op[1:0]
- MC_wdata  out  32  rs2, low bytes significant
- MC_done  in  1  one-cycle completion pulse
- MC_rdata  in  32  raw read data, valid with MC_done
- ROB_commit_valid  in  1
- ROB_commit_id  in  ROB_ID_W
- ROB_clear  in  1  mispredict flush
- CDB_valid  out  1  one-cycle pulse
- CDB_ROB_id  out  ROB_ID_W
- CDB_value  out  32
- CDB_addr  out  32

Behaviour:
- Reset (async):
  - state=IDLE.
  - All outputs 0: LSB_busy, MC_req_valid, MC_is_write, MC_addr, MC_size, MC_wdata, CDB_valid, CDB_ROB_id, CDB_value, CDB_addr.
- LSB_busy = (state != IDLE). Issue is accepted only when LSB_input_valid && state==IDLE.
  - Issue while busy is a protocol violation and is ignored.
  - Acceptance latches op, rs2, tag and addr = rs1+imm, modulo 2^32 (wrap-around ignored).
- States: IDLE, MEM_WAIT, STORE_WAIT, DRAIN.
- Load path:
  - Accept → next cycle MEM_WAIT with MC_req_valid=1, MC_is_write=0.
  - On MC_done: MC_req_valid=0; next cycle CDB_valid=1 with the extended value and CDB_addr=addr; state IDLE.
  - Extension:
    - byte: signed replicates bit7, unsigned zero-fills.
    - half: bit15 / zero-fill.
    - word: passthrough; the unsigned bit is ignored.
  - Minimum load latency: accept→CDB = MC latency + 2 cycles.
- Store path:
  - Accept → next cycle CDB_valid=1 (value=rs2, addr) and state STORE_WAIT.
  - Leave STORE_WAIT when ROB_commit_valid && ROB_commit_id==tag: next cycle MEM_WAIT with MC_is_write=1, wdata=rs2.
  - On MC_done → IDLE. No second CDB pulse.
- ROB_clear:
  - In STORE_WAIT → IDLE next cycle; no memory write occurs.
  - In load MEM_WAIT → DRAIN: keep MC_req_valid until MC_done, then IDLE with no CDB.
  - Committed store in MEM_WAIT: unaffected, completes normally.
  - IDLE with simultaneous LSB_input_valid: the issue is dropped.
  - Pending CDB pulse in the same cycle: suppressed.
- ROB_clear and commit of the held store in the same cycle: commit wins (the store is architecturally committed).
- MC_done outside MEM_WAIT/DRAIN: ignored.
- CDB_valid is never high for two consecutive cycles.
- rdy=0 mid-transaction: state frozen; MC_done during rdy=0 is not sampled (the memory controller shares rdy).

Optional Feature:
- Macro LS_IO_ORDER_EN.
- Defined: a load with addr[17:16]==IO_BASE_HI does not access memory speculatively.
  - It emits no early CDB and enters STORE_WAIT-style gating (waits for ROB commit of its tag), then performs the read and broadcasts on CDB.
  - ROB_clear while waiting → IDLE.
- Undefined: IO loads behave as ordinary loads.

Test Plan:
- Signed byte load: rs1=0x100, imm=0xFFFFFFFC, op=0000, MC_rdata=0x000000F0 after 3 cycles → MC_addr=0xFC, CDB_value=0xFFFFFFF0, tag echoed, single pulse.
- Unsigned half load: op=0101, rdata=0x1234ABCD → CDB_value=0x0000ABCD; LSB_busy high from accept until the CDB cycle.
- Store gating: op=1010, rs2=0xDEADBEEF, tag=5 → CDB pulse next cycle. No MC_req_valid until ROB_commit_id=5 (commit of id=4 has no effect), then write of 0xDEADBEEF completes → IDLE.
- Clear in STORE_WAIT → no MC_req ever. Clear during a load in MEM_WAIT → MC_req held until MC_done, no CDB, then a new issue is accepted.
- Async reset asserted mid-MEM_WAIT without clk edge → all outputs 0 immediately. rdy=0 for 4 cycles mid-load → result delayed by exactly 4 cycles.
- LS_IO_ORDER_EN: load at 0x30000 → no MC_req until commit of its tag, then CDB. Without the macro → immediate MC_req.
